// File: rtl/pixel_reorder_buffer.sv
// rtl/pixel_reorder_buffer.sv - Round-robin merge of per-core pixel FIFOs into one framed pixel stream
// Optional PIXBUF_STATS_EN adds saturating stat_pixels / stat_stalls counters.
module pixel_reorder_buffer #(
  parameter int NUM_CORES  = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int DIM_W      = 12,
  localparam int CM_W      = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1,
  localparam int AW        = $clog2(FIFO_DEPTH)
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    start,
  input  logic [CM_W-1:0]         cores_m1,
  input  logic [DIM_W-1:0]        line_width,
  input  logic [DIM_W-1:0]        frame_lines,
  input  logic [24*NUM_CORES-1:0] core_pixel,
  input  logic [NUM_CORES-1:0]    core_valid,
  output logic [NUM_CORES-1:0]    core_ready,
  output logic [23:0]             out_pixel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_user,
  output logic                    out_last,
  output logic                    busy
`ifdef PIXBUF_STATS_EN
  ,
  output logic [31:0]             stat_pixels,
  output logic [31:0]             stat_stalls
`endif
);

  localparam logic [CM_W-1:0] MAX_M1 = CM_W'(NUM_CORES - 1);
  localparam logic [AW:0]     DEPTH  = (AW+1)'(FIFO_DEPTH);

  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;

  logic [CM_W-1:0]  cfg_m1, rr_ptr;
  logic [DIM_W-1:0] cfg_wm1, cfg_hm1, x, y;
  logic             out_eof;

  logic [23:0]   mem    [NUM_CORES][FIFO_DEPTH];
  logic [AW-1:0] wr_ptr [NUM_CORES];
  logic [AW-1:0] rd_ptr [NUM_CORES];
  logic [AW:0]   count  [NUM_CORES];

  logic [NUM_CORES-1:0] push, pop;
  logic                 sel_empty, load, handshake, frame_done;

  assign busy       = (state == RUN);
  assign sel_empty  = (count[rr_ptr] == '0);
  assign handshake  = out_valid && out_ready;
  assign frame_done = handshake && out_eof;
  // Once the end-of-frame pixel is in the output register nothing else is loaded behind it.
  assign load = (state == RUN) && !sel_empty && (!out_valid || out_ready) && !(out_valid && out_eof);

  always_comb begin
    core_ready = '0;
    push       = '0;
    pop        = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      core_ready[i] = (state == RUN) && (count[i] != DEPTH) && (i <= int'(cfg_m1));
      push[i]       = core_valid[i] && core_ready[i];
      pop[i]        = load && (rr_ptr == CM_W'(i));
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (frame_done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    for (int i = 0; i < NUM_CORES; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= core_pixel[24*i +: 24];
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      cfg_m1    <= '0;
      cfg_wm1   <= '0;
      cfg_hm1   <= '0;
      rr_ptr    <= '0;
      x         <= '0;
      y         <= '0;
      out_pixel <= '0;
      out_valid <= 1'b0;
      out_user  <= 1'b0;
      out_last  <= 1'b0;
      out_eof   <= 1'b0;
      for (int i = 0; i < NUM_CORES; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      if (state == IDLE && start) begin
        cfg_m1  <= (int'(cores_m1) > NUM_CORES - 1) ? MAX_M1 : cores_m1;
        cfg_wm1 <= (line_width == '0) ? '0 : line_width - 1'b1;
        cfg_hm1 <= (frame_lines == '0) ? '0 : frame_lines - 1'b1;
        rr_ptr  <= '0;
        x       <= '0;
        y       <= '0;
      end
      if (frame_done) begin
        out_valid <= 1'b0;
        for (int i = 0; i < NUM_CORES; i++) begin
          wr_ptr[i] <= '0;
          rd_ptr[i] <= '0;
          count[i]  <= '0;
        end
      end else begin
        if (handshake) out_valid <= 1'b0;
        if (load) begin
          out_valid <= 1'b1;
          out_pixel <= mem[rr_ptr][rd_ptr[rr_ptr]];
          out_user  <= (x == '0) && (y == '0);
          out_last  <= (x == cfg_wm1);
          out_eof   <= (x == cfg_wm1) && (y == cfg_hm1);
          rr_ptr    <= (rr_ptr == cfg_m1) ? '0 : rr_ptr + 1'b1;
          if (x == cfg_wm1) begin
            x <= '0;
            y <= (y == cfg_hm1) ? '0 : y + 1'b1;
          end else begin
            x <= x + 1'b1;
          end
        end
        for (int i = 0; i < NUM_CORES; i++) begin
          if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
          if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
          if (push[i] && !pop[i])      count[i] <= count[i] + 1'b1;
          else if (!push[i] && pop[i]) count[i] <= count[i] - 1'b1;
        end
      end
    end
  end

`ifdef PIXBUF_STATS_EN
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      stat_pixels <= '0;
      stat_stalls <= '0;
    end else if (state == IDLE && start) begin
      stat_pixels <= '0;
      stat_stalls <= '0;
    end else begin
      if (handshake && stat_pixels != '1)               stat_pixels <= stat_pixels + 1'b1;
      if (out_valid && !out_ready && stat_stalls != '1) stat_stalls <= stat_stalls + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pixel_reorder_buffer.sv
// tb/tb_pixel_reorder_buffer.sv - Self-checking bench for pixel_reorder_buffer
// Reference model: per-core pushed-pixel queues; output k comes from core k mod N, framing from k, W, H.
module tb_pixel_reorder_buffer;
  localparam int NC    = 4;
  localparam int DEPTH = 4;
  localparam int DW    = 12;
  localparam int CMW   = 2;

  logic            aclk = 1'b0;
  logic            areset, start, out_ready;
  logic [CMW-1:0]  cores_m1;
  logic [DW-1:0]   line_width, frame_lines;
  logic [24*NC-1:0] core_pixel;
  logic [NC-1:0]   core_valid, core_ready;
  logic [23:0]     out_pixel;
  logic            out_valid, out_user, out_last, busy;
`ifdef PIXBUF_STATS_EN
  logic [31:0]     stat_pixels, stat_stalls;
`endif

  always #5 aclk = ~aclk;

  pixel_reorder_buffer #(.NUM_CORES(NC), .FIFO_DEPTH(DEPTH), .DIM_W(DW)) dut (
    .aclk(aclk), .areset(areset), .start(start), .cores_m1(cores_m1),
    .line_width(line_width), .frame_lines(frame_lines), .core_pixel(core_pixel),
    .core_valid(core_valid), .core_ready(core_ready), .out_pixel(out_pixel),
    .out_valid(out_valid), .out_ready(out_ready), .out_user(out_user),
    .out_last(out_last), .busy(busy)
`ifdef PIXBUF_STATS_EN
    , .stat_pixels(stat_pixels), .stat_stalls(stat_stalls)
`endif
  );

  int total = 0;
  int passed = 0;
  int n_act = 1, we = 1, p = 1;
  int out_cnt = 0, n_last = 0, n_user = 0;
  int nxt [NC];
  logic [23:0] mq [NC][$];
  bit prev_stall = 0;
  logic [25:0] prev_word = '0;

  typedef struct {
    int m1;
    int w;
    int h;
    int exp_pix;
    int exp_last;
  } frame_vec_t;
  frame_vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  // One clock: check stall stability, record the handshakes the DUT sees at the coming edge, advance.
  task automatic tick();
    int c, k;
    if (prev_stall) begin
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_word", {6'd0, out_user, out_last, out_pixel}, {6'd0, prev_word});
    end
    if (out_valid && out_ready) begin
      c = out_cnt % n_act;
      k = out_cnt % p;
      if (mq[c].size() == 0) begin
        total++;
        $display("FAIL out_source: output %0d emitted but core %0d has nothing pending", out_cnt, c);
      end else begin
        chk("out_pixel", {8'd0, out_pixel}, {8'd0, mq[c].pop_front()});
      end
      chk("out_user", {31'd0, out_user}, {31'd0, k == 0});
      chk("out_last", {31'd0, out_last}, {31'd0, (k % we) == we - 1});
      if (out_last) n_last++;
      if (out_user) n_user++;
      out_cnt++;
    end
    for (int i = 0; i < NC; i++) begin
      if (core_valid[i] && core_ready[i]) begin
        mq[i].push_back(core_pixel[24*i +: 24]);
        nxt[i] += n_act;
      end
    end
    prev_stall = out_valid && !out_ready;
    prev_word  = {out_user, out_last, out_pixel};
    @(posedge aclk);
    #1;
  endtask

  task automatic begin_frame(input int m1, input int w, input int h);
    n_act = m1 + 1;
    we    = (w == 0) ? 1 : w;
    p     = we * ((h == 0) ? 1 : h);
    out_cnt = 0; n_last = 0; n_user = 0; prev_stall = 0;
    for (int i = 0; i < NC; i++) begin
      mq[i].delete();
      nxt[i] = i;
    end
    core_valid  = '0;
    cores_m1    = CMW'(m1);
    line_width  = DW'(w);
    frame_lines = DW'(h);
    start = 1'b1;
    tick();
    start = 1'b0;
    cores_m1    = CMW'($urandom);
    line_width  = DW'($urandom);
    frame_lines = DW'($urandom);
    chk("start_busy", {31'd0, busy}, 32'd1);
  endtask

  task automatic drive_until_done(input bit rnd);
    int cyc;
    bit bad_ready;
    int left;
    cyc = 0;
    bad_ready = 0;
    while (busy && cyc < 400) begin
      for (int i = 0; i < NC; i++) begin
        if (i >= n_act) begin
          core_valid[i] = 1'b1;
        end else if (nxt[i] < p) begin
          core_valid[i] = rnd ? 1'($urandom) : 1'b1;
          core_pixel[24*i +: 24] = rnd ? 24'($urandom) : 24'(nxt[i]);
        end else begin
          core_valid[i] = 1'b0;
        end
      end
      out_ready = rnd ? ($urandom_range(3) != 0) : 1'b1;
      for (int i = n_act; i < NC; i++) if (core_ready[i]) bad_ready = 1;
      tick();
      cyc++;
    end
    core_valid = '0;
    out_ready  = 1'b1;
    left = 0;
    for (int i = 0; i < NC; i++) left += mq[i].size();
    chk("inactive_ready", {31'd0, bad_ready}, 32'd0);
    chk("frame_done", {31'd0, busy}, 32'd0);
    chk("pixel_count", out_cnt, p);
    chk("model_leftover", left, 0);
    chk("idle_valid", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acc;
    areset = 1'b1; start = 1'b0; cores_m1 = '0; line_width = '0; frame_lines = '0;
    core_pixel = '0; core_valid = '0; out_ready = 1'b1;
    for (int i = 0; i < NC; i++) nxt[i] = i;
    repeat (2) @(posedge aclk);
    #1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_user", {31'd0, out_user}, 32'd0);
    chk("rst_last", {31'd0, out_last}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {28'd0, core_ready}, 32'd0);
    chk("rst_pixel", {8'd0, out_pixel}, 32'd0);
    areset = 1'b0;
    tick();
    chk("idle_ready", {28'd0, core_ready}, 32'd0);

    vecs[0] = '{3, 4, 2, 8, 2};
    vecs[1] = '{1, 3, 2, 6, 2};
    vecs[2] = '{0, 0, 0, 1, 1};
    vecs[3] = '{2, 5, 1, 5, 1};
    vecs[4] = '{3, 1, 3, 3, 3};
    for (int r = 0; r < 5; r++) begin
      begin_frame(vecs[r].m1, vecs[r].w, vecs[r].h);
      drive_until_done(0);
      chk("vec_pixels", out_cnt, vecs[r].exp_pix);
      chk("vec_last", n_last, vecs[r].exp_last);
      chk("vec_user", n_user, 1);
`ifdef PIXBUF_STATS_EN
      chk("vec_stat_pixels", stat_pixels, vecs[r].exp_pix);
      chk("vec_stat_stalls", stat_stalls, 0);
`endif
    end

    // Backpressure on a single-core frame: output register plus a full FIFO, then drain.
    begin_frame(0, 8, 1);
    out_ready = 1'b0;
    core_valid[0] = 1'b1;
    core_pixel[23:0] = 24'(nxt[0]);
    tick();
    core_valid[0] = 1'b0;
    chk("latency_early", {31'd0, out_valid}, 32'd0);
    tick();
    chk("latency_valid", {31'd0, out_valid}, 32'd1);
    acc = 0;
    for (int j = 0; j < DEPTH + 1; j++) begin
      core_valid[0] = 1'b1;
      core_pixel[23:0] = 24'(nxt[0]);
      if (core_ready[0]) acc++;
      tick();
    end
    core_valid[0] = 1'b0;
    chk("bp_accepted", acc, DEPTH);
    chk("bp_full_ready", {31'd0, core_ready[0]}, 32'd0);
    chk("bp_pixel", {8'd0, out_pixel}, 32'd0);
    drive_until_done(0);

    // Core 1 data waits behind an empty core 0.
    begin_frame(1, 2, 1);
    out_ready = 1'b1;
    core_valid[1] = 1'b1;
    core_pixel[47:24] = 24'(nxt[1]);
    tick();
    core_valid[1] = 1'b0;
    for (int j = 0; j < 3; j++) begin
      tick();
      chk("strict_order_stall", {31'd0, out_valid}, 32'd0);
    end
    drive_until_done(0);

    // Reset mid-frame with full FIFOs; tagged values expose any residue in the next frame.
    begin_frame(3, 4, 4);
    out_ready = 1'b0;
    for (int j = 0; j < 8; j++) begin
      for (int i = 0; i < NC; i++) begin
        core_valid[i] = 1'b1;
        core_pixel[24*i +: 24] = 24'h800000 | 24'(nxt[i]);
      end
      tick();
    end
    chk("pre_rst_ready", {28'd0, core_ready}, 32'd0);
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    areset = 1'b1;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_ready", {28'd0, core_ready}, 32'd0);
    chk("arst_pixel", {8'd0, out_pixel}, 32'd0);
    chk("arst_flags", {30'd0, out_user, out_last}, 32'd0);
`ifdef PIXBUF_STATS_EN
    chk("arst_stat_pixels", stat_pixels, 0);
    chk("arst_stat_stalls", stat_stalls, 0);
`endif
    prev_stall = 0;
    core_valid = '0;
    out_ready = 1'b1;
    @(posedge aclk);
    #1;
    areset = 1'b0;
    tick();
    begin_frame(3, 4, 2);
    drive_until_done(0);

    for (int r = 0; r < 20; r++) begin
      begin_frame($urandom_range(3), $urandom_range(5), $urandom_range(3));
      drive_until_done(1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
